// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A and one B matrix and streams them
// into the PE grid edges with a one-cycle-per-lane diagonal skew.
module systolic_feeder #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic            wr_mat,
   input  logic [IW-1:0]   wr_row,
   input  logic [IW-1:0]   wr_col,
   input  logic [7:0]      wr_data,
   output logic            wr_err,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [N*8-1:0]  a_out,
   output logic [N-1:0]    a_valid,
   output logic [N*8-1:0]  b_out,
   output logic [N-1:0]    b_valid
);

   localparam int TW = $clog2(2*N-1);
   localparam logic [TW-1:0] LAST = TW'(2*N-2);
   localparam logic [IW:0]   NV   = (IW+1)'(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [TW-1:0] t;
   logic [7:0]    a_mem [N][N];
   logic [7:0]    b_mem [N][N];

   logic start_acc;
   logic load;
   logic clear;
   logic in_range;
   logic wr_ok;
   int   step;

   logic [N*8-1:0] nxt_a;
   logic [N*8-1:0] nxt_b;
   logic [N-1:0]   nxt_av;
   logic [N-1:0]   nxt_bv;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      load      = 1'b0;
      clear     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               load      = 1'b1;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (t == LAST) begin
               clear     = 1'b1;
               state_nxt = S_DONE;
            end else begin
               load = 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy = (state == S_STREAM);
   assign done = (state == S_DONE);

   assign in_range = ({1'b0, wr_row} < NV) && ({1'b0, wr_col} < NV);
   assign wr_ok    = wr_en && (state == S_IDLE) && !start && in_range;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t <= '0;
      end else if (start_acc) begin
         t <= '0;
      end else if (clear) begin
         t <= '0;
      end else if (state == S_STREAM) begin
         t <= t + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_mem[r][c] <= '0;
               b_mem[r][c] <= '0;
            end
         end
      end else if (wr_ok) begin
         if (wr_mat) begin
            b_mem[wr_row][wr_col] <= wr_data;
         end else begin
            a_mem[wr_row][wr_col] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_ok;
      end
   end

   // The step being loaded: 0 on the start edge, otherwise the one after t.
   always_comb begin
      step   = start_acc ? 0 : int'(t) + 1;
      nxt_a  = '0;
      nxt_b  = '0;
      nxt_av = '0;
      nxt_bv = '0;
      for (int i = 0; i < N; i++) begin
         if ((step >= i) && (step - i < N)) begin
            nxt_a[i*8 +: 8] = a_mem[i][IW'(step - i)];
            nxt_b[i*8 +: 8] = b_mem[IW'(step - i)][i];
            nxt_av[i]       = 1'b1;
            nxt_bv[i]       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_out   <= '0;
         b_out   <= '0;
         a_valid <= '0;
         b_valid <= '0;
      end else if (load) begin
         a_out   <= nxt_a;
         b_out   <= nxt_b;
         a_valid <= nxt_av;
         b_valid <= nxt_bv;
      end else if (clear) begin
         a_out   <= '0;
         b_out   <= '0;
         a_valid <= '0;
         b_valid <= '0;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard plus vector-table bench for the
// skewed A/B matrix feeder at N=4.
module tb_systolic_feeder;

   localparam int N = 4;

   logic        clk = 0;
   logic        reset = 1;
   logic        wr_en = 0;
   logic        wr_mat = 0;
   logic [1:0]  wr_row = 0;
   logic [1:0]  wr_col = 0;
   logic [7:0]  wr_data = 0;
   logic        start = 0;
   logic        wr_err;
   logic        busy;
   logic        done;
   logic [31:0] a_out;
   logic [3:0]  a_valid;
   logic [31:0] b_out;
   logic [3:0]  b_valid;

   systolic_feeder #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_mat  (wr_mat),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .wr_err  (wr_err),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .a_out   (a_out),
      .a_valid (a_valid),
      .b_out   (b_out),
      .b_valid (b_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  av;
      logic [3:0]  bv;
      logic        busy;
      logic        done;
   } exp_t;

   typedef struct {
      int         step;
      int         lane;
      logic [7:0] a;
      logic [7:0] b;
      logic       av;
      logic       bv;
   } vec_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   bit          last_done = 0;
   bit          err_exp = 0;
   logic [7:0]  ma [4][4];
   logic [7:0]  mb [4][4];
   logic [31:0] la[$], lb[$], sa[$], sb[$];
   logic [3:0]  lav[$], lbv[$];
   int          cyc, busy_n, done_n, done_at;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic exp_t build(int s);
      exp_t e;
      e = '0;
      e.busy = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (s - i >= 0 && s - i < N) begin
            e.a[i*8 +: 8] = ma[i][s-i];
            e.b[i*8 +: 8] = mb[s-i][i];
            e.av[i] = 1'b1;
            e.bv[i] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic tick();
      exp_t e;
      bit   idle;
      bit   acc;
      idle = (q.size() == 0) && !last_done;
      acc = idle && start;
      err_exp = 0;
      if (wr_en) begin
         if (idle && !acc) begin
            if (wr_mat) mb[wr_row][wr_col] = wr_data;
            else ma[wr_row][wr_col] = wr_data;
         end else begin
            err_exp = 1;
         end
      end
      if (acc) begin
         for (int s = 0; s < 2*N-1; s++) q.push_back(build(s));
         e = '0;
         e.done = 1'b1;
         q.push_back(e);
      end
      @(negedge clk);
      cyc++;
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      last_done = e.done;
      chk("wr_err", 32'(wr_err), 32'(err_exp));
      chk("a_out", a_out, e.a);
      chk("b_out", b_out, e.b);
      chk("a_valid", 32'(a_valid), 32'(e.av));
      chk("b_valid", 32'(b_valid), 32'(e.bv));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      if (busy) begin
         busy_n++;
         la.push_back(a_out);
         lb.push_back(b_out);
         lav.push_back(a_valid);
         lbv.push_back(b_valid);
      end
      if (done) begin
         done_n++;
         if (done_at == 0) done_at = cyc;
      end
   endtask

   task automatic clr_log();
      la.delete();
      lb.delete();
      lav.delete();
      lbv.delete();
      cyc = 0;
      busy_n = 0;
      done_n = 0;
      done_at = 0;
   endtask

   task automatic wr(logic m, int r, int c, logic [7:0] d);
      wr_en = 1;
      wr_mat = m;
      wr_row = 2'(r);
      wr_col = 2'(c);
      wr_data = d;
      tick();
      wr_en = 0;
   endtask

   task automatic run_stream();
      clr_log();
      start = 1;
      tick();
      start = 0;
      repeat (8) tick();
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_a_out"}, a_out, 32'h0);
      chk({nm, "_b_out"}, b_out, 32'h0);
      chk({nm, "_valid"}, 32'({a_valid, b_valid}), 32'h0);
      chk({nm, "_flags"}, 32'({busy, done, wr_err}), 32'h0);
   endtask

   initial begin
      vec_t tbl[8];
      logic [31:0] w;
      tbl[0] = '{3, 0, 8'd3,  8'd112, 1'b1, 1'b1};
      tbl[1] = '{3, 1, 8'd18, 8'd97,  1'b1, 1'b1};
      tbl[2] = '{3, 2, 8'd33, 8'd82,  1'b1, 1'b1};
      tbl[3] = '{3, 3, 8'd48, 8'd67,  1'b1, 1'b1};
      tbl[4] = '{0, 0, 8'd0,  8'd64,  1'b1, 1'b1};
      tbl[5] = '{0, 1, 8'd0,  8'd0,   1'b0, 1'b0};
      tbl[6] = '{6, 3, 8'd51, 8'd115, 1'b1, 1'b1};
      tbl[7] = '{6, 0, 8'd0,  8'd0,   1'b0, 1'b0};
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 0;
            mb[r][c] = 0;
         end
      end
      clr_log();

      #1 reset = 0;
      #2 chk_zero("reset");
      @(negedge clk);
      reset = 1;
      tick();

      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) wr(0, i, k, 8'(16*i + k));
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++) wr(1, k, j, 8'(16*k + j + 64));
      run_stream();
      chk("busy_cycles", 32'(busy_n), 32'd7);
      chk("done_cycle", 32'(done_at), 32'd8);
      for (int v = 0; v < 8; v++) begin
         w = la[tbl[v].step];
         chk($sformatf("tbl%0d_a", v), 32'(w[tbl[v].lane*8 +: 8]), 32'(tbl[v].a));
         w = lb[tbl[v].step];
         chk($sformatf("tbl%0d_b", v), 32'(w[tbl[v].lane*8 +: 8]), 32'(tbl[v].b));
         w = 32'(lav[tbl[v].step]);
         chk($sformatf("tbl%0d_av", v), 32'(w[tbl[v].lane]), 32'(tbl[v].av));
         w = 32'(lbv[tbl[v].step]);
         chk($sformatf("tbl%0d_bv", v), 32'(w[tbl[v].lane]), 32'(tbl[v].bv));
      end
      sa = la;
      sb = lb;

      clr_log();
      start = 1;
      tick();
      start = 0;
      tick();
      tick();
      wr_en = 1;
      wr_mat = 0;
      wr_row = 1;
      wr_col = 1;
      wr_data = 99;
      tick();
      wr_en = 0;
      repeat (5) tick();
      chk("replay_len", 32'(la.size()), 32'(sa.size()));
      for (int s = 0; s < la.size() && s < sa.size(); s++) begin
         chk($sformatf("replay_a%0d", s), la[s], sa[s]);
         chk($sformatf("replay_b%0d", s), lb[s], sb[s]);
      end

      clr_log();
      wr_en = 1;
      wr_row = 1;
      wr_col = 1;
      wr_data = 99;
      start = 1;
      tick();
      wr_en = 0;
      start = 0;
      repeat (8) tick();
      run_stream();
      w = la[2];
      chk("a11_kept", 32'(w[15:8]), 32'd17);

      wr(0, 0, 0, 8'h80);
      wr(1, 0, 0, 8'h7F);
      run_stream();
      chk("neg_a", la[0], 32'h0000_0080);
      chk("pos_b", lb[0], 32'h0000_007F);
      chk("ext_av", 32'(lav[0]), 32'h1);
      chk("ext_bv", 32'(lbv[0]), 32'h1);

      clr_log();
      start = 1;
      repeat (10) tick();
      start = 0;
      repeat (8) tick();
      chk("held_busy", 32'(busy_n), 32'd14);
      chk("held_done_n", 32'(done_n), 32'd2);
      chk("held_done_at", 32'(done_at), 32'd8);

      clr_log();
      start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      #2 reset = 0;
      #1 chk_zero("async_rst");
      q.delete();
      last_done = 0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 0;
            mb[r][c] = 0;
         end
      end
      tick();
      reset = 1;
      tick();
      run_stream();
      chk("zero_a3", la[3], 32'h0);
      chk("zero_av3", 32'(lav[3]), 32'hF);
      chk("zero_busy", 32'(busy_n), 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
